// File: rtl/fft_addr_gen_if.sv
// Control and address bundle between the FFT sequencer and the address generator.
interface fft_addr_gen_if #(
    parameter int LOG2N = 4
);
    logic             start_i;
    logic             step_i;
    logic             clear_i;
    logic [LOG2N-1:0] addr_a_o;
    logic [LOG2N-1:0] addr_b_o;
    logic [LOG2N-2:0] tw_idx_o;
    logic [3:0]       stage_o;
    logic             valid_o;
    logic             last_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, step_i, clear_i,
        input  addr_a_o, addr_b_o, tw_idx_o, stage_o,
        input  valid_o, last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, step_i, clear_i,
        output addr_a_o, addr_b_o, tw_idx_o, stage_o,
        output valid_o, last_o, busy_o, done_o
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT butterfly address and twiddle index sequencer.
// Walks LOG2N stages of N/2 butterflies, advancing one butterfly per step.
module fft_addr_gen #(
    parameter int LOG2N = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fft_addr_gen_if.slave       bus
);
    localparam int KW = LOG2N - 1;
    localparam logic [3:0] S_LAST = 4'(LOG2N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [3:0]    stage_q, stage_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        if (bus.clear_i) begin
            state_d = IDLE;
            k_d     = '0;
            stage_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_d = RUN;
                        k_d     = '0;
                        stage_d = '0;
                    end
                end
                RUN: begin
                    if (bus.step_i) begin
                        if (k_q != '1) begin
                            k_d = k_q + KW'(1);
                        end else if (stage_q != S_LAST) begin
                            k_d     = '0;
                            stage_d = stage_q + 4'd1;
                        end else begin
                            state_d = DONE;
                            k_d     = '0;
                            stage_d = '0;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                    stage_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
        end
    end

    // Outputs decode registered state only; no input reaches them.
    logic             run;
    logic [LOG2N-1:0] kx, mask, half, a_w, b_w;
    logic [KW-1:0]    tw_w;

    always_comb begin
        run  = (state_q == RUN);
        kx   = LOG2N'(k_q);
        half = LOG2N'(1) << stage_q;
        mask = half - LOG2N'(1);
        a_w  = ((kx >> stage_q) << (stage_q + 4'd1)) | (kx & mask);
        b_w  = a_w + half;
        tw_w = (k_q & mask[KW-1:0]) << (4'(KW) - stage_q);
    end

    assign bus.valid_o  = run;
    assign bus.addr_a_o = run ? a_w : '0;
    assign bus.addr_b_o = run ? b_w : '0;
    assign bus.tw_idx_o = run ? tw_w : '0;
    assign bus.stage_o  = run ? stage_q : '0;
    assign bus.last_o   = run && (stage_q == S_LAST) && (k_q == '1);
    assign bus.busy_o   = (state_q == RUN) || (state_q == DONE);
    assign bus.done_o   = (state_q == DONE);
endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen at LOG2N=4 (N=16, 32 butterflies).
module tb_fft_addr_gen;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   steps;
    int   hist [16];
    logic st;
    logic [3:0] pa, pb, ps;
    logic [2:0] pt;

    fft_addr_gen_if #(.LOG2N(4)) bus ();

    fft_addr_gen #(.LOG2N(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bf(input string tag, input int a, input int b,
                          input int tw, input int s);
        chk({tag, "_a"}, 32'(bus.addr_a_o), 32'(a));
        chk({tag, "_b"}, 32'(bus.addr_b_o), 32'(b));
        chk({tag, "_tw"}, 32'(bus.tw_idx_o), 32'(tw));
        chk({tag, "_stage"}, 32'(bus.stage_o), 32'(s));
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_a"}, 32'(bus.addr_a_o), 32'd0);
        chk({tag, "_b"}, 32'(bus.addr_b_o), 32'd0);
        chk({tag, "_tw"}, 32'(bus.tw_idx_o), 32'd0);
        chk({tag, "_stage"}, 32'(bus.stage_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start_i = 1'b0;
        bus.step_i  = 1'b0;
        bus.clear_i = 1'b0;
        rst_n = 1'b0;
        #12;
        chk_idle("reset");
        chk("reset_last", 32'(bus.last_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full run, step tied high, spot checks on known butterflies.
        bus.start_i = 1'b1;
        bus.step_i  = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk_bf("s0k0", 0, 1, 0, 0);
        chk("s0k0_busy", 32'(bus.busy_o), 32'd1);
        tick_n(3);
        chk_bf("s0k3", 6, 7, 0, 0);
        tick_n(6);
        chk_bf("s1k1", 1, 3, 4, 1);
        tick_n(12);
        chk_bf("s2k5", 9, 13, 2, 2);
        tick_n(9);
        chk_bf("s3k6", 6, 14, 6, 3);
        chk("s3k6_last", 32'(bus.last_o), 32'd0);
        tick();
        chk_bf("s3k7", 7, 15, 7, 3);
        chk("s3k7_last", 32'(bus.last_o), 32'd1);
        tick();
        chk("done_pulse", 32'(bus.done_o), 32'd1);
        chk("done_busy", 32'(bus.busy_o), 32'd1);
        chk("done_valid", 32'(bus.valid_o), 32'd0);
        chk("done_last", 32'(bus.last_o), 32'd0);
        tick();
        chk_idle("after_done");

        // Random stalls: outputs hold while step_i=0; coverage of addresses.
        for (int i = 0; i < 16; i++) hist[i] = 0;
        steps = 0;
        bus.step_i  = 1'b0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int c = 0; c < 400 && !bus.done_o; c++) begin
            st = 1'($urandom_range(0, 1));
            bus.step_i = st;
            pa = bus.addr_a_o;
            pb = bus.addr_b_o;
            pt = bus.tw_idx_o;
            ps = bus.stage_o;
            tick();
            if (!st) begin
                chk("hold_a", 32'(bus.addr_a_o), 32'(pa));
                chk("hold_b", 32'(bus.addr_b_o), 32'(pb));
                chk("hold_tw", 32'(bus.tw_idx_o), 32'(pt));
                chk("hold_stage", 32'(bus.stage_o), 32'(ps));
                chk("hold_valid", 32'(bus.valid_o), 32'd1);
            end else begin
                steps++;
                hist[pa]++;
                hist[pb]++;
            end
        end
        chk("stall_done", 32'(bus.done_o), 32'd1);
        chk("stall_steps", 32'(steps), 32'd32);
        for (int i = 0; i < 16; i++)
            chk($sformatf("hist_%0d", i), 32'(hist[i]), 32'd4);
        bus.step_i = 1'b0;
        tick();

        // Clear at stage 2 k=3 together with step.
        bus.start_i = 1'b1;
        bus.step_i  = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick_n(19);
        chk_bf("s2k3", 3, 7, 6, 2);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        chk_idle("clear");
        tick();
        chk_idle("clear_hold");
        tick();
        chk("clear_no_done", 32'(bus.done_o), 32'd0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk_bf("restart", 0, 1, 0, 0);

        // Asynchronous reset mid stage 1.
        tick_n(10);
        chk_bf("s1k2", 4, 6, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_last", 32'(bus.last_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(3);
        chk_idle("rst_wait");
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk_bf("rst_restart", 0, 1, 0, 0);
        steps = 0;
        for (int c = 0; c < 100 && !bus.done_o; c++) begin
            if (bus.valid_o) steps++;
            tick();
        end
        chk("rst_seq_steps", 32'(steps), 32'd32);
        chk("rst_seq_done", 32'(bus.done_o), 32'd1);
        tick();

        // start_i held high throughout: latency, ignored in RUN/DONE.
        steps = 0;
        bus.start_i = 1'b1;
        bus.step_i  = 1'b1;
        cyc = 1;
        for (int c = 0; c < 100 && !bus.done_o; c++) begin
            if (bus.valid_o) steps++;
            tick();
            cyc++;
        end
        chk("lat_cycles", 32'(cyc), 32'd34);
        chk("lat_steps", 32'(steps), 32'd32);
        chk("lat_done", 32'(bus.done_o), 32'd1);
        tick();
        chk_idle("held_idle");
        tick();
        chk_bf("held_rerun", 0, 1, 0, 0);
        bus.start_i = 1'b0;
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        chk_idle("final_clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
